xgriscv_lsu: RTL and testbench
==============================

# xgriscv_lsu

Load/store unit at the MEM stage of the xgriscv pipeline. It is the consuming end of the memory-control signals that the controller produces (memwrite, lwhb, swhb, lunsigned). It turns one load or store per instruction into a req/gnt/rvalid transaction on a 32-bit word-addressed data bus, stalls the pipeline until the transaction completes, and returns read data that has been lane-aligned and sign- or zero-extended. Misaligned or illegal-size accesses never reach the bus; they are flagged instead.

## Interface
- XLEN, 32, data and address width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- valid_i  in  1  MEM-stage instruction is a load or store (memtoreg | memwrite); held stable while stall is high.
- memwrite  in  1  1 = store, 0 = load.
- lwhb  in  2  load size: 11 = word, 10 = half, 01 = byte, 00 = illegal.
- swhb  in  2  store size, same encoding as lwhb.
- lunsigned  in  1  zero-extend load data (lbu/lhu).
- addr  in  XLEN  byte address from the ALU.
- wdata  in  XLEN  store data (rs2).
- stall  out  1  holds IF/ID/EX/MEM.
- rdata  out  XLEN  extended load result; registered.
- done  out  1  one-cycle pulse when the access completes.
- misalign  out  1  one-cycle pulse: misaligned or illegal-size access, no bus traffic.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  XLEN  {addr[XLEN-1:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_gnt  in  1  request accepted.
- mem_rvalid  in  1  response; marks read data valid, or acknowledges a write.
- mem_rdata  in  XLEN  raw word.

## Operation
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - If valid_i and the access is legal, latch we, size, lunsigned, addr[1:0], mem_addr, mem_be and mem_wdata, then go to REQ.
  - If valid_i and the access is illegal, pulse misalign in the next cycle, then go to DONE.
  - Otherwise stay in IDLE.
- **REQ:** mem_req = 1 with stable outputs until mem_gnt.
  - mem_gnt without mem_rvalid: go to WAIT.
  - mem_gnt and mem_rvalid in the same cycle: go to DONE.
- **WAIT:** mem_req = 0. On mem_rvalid, capture rdata for loads, then go to DONE.
- **DONE:** done = 1 (legal access only) and stall = 0, so the pipeline advances at the end of this cycle. valid_i is ignored here. Next state is IDLE.
- **stall** = (IDLE & valid_i) | REQ | WAIT. It is forced to 0 while reset is high.
- **Legality:**
  - Size 00 is illegal.
  - Half-word access needs addr[0] = 0.
  - Word access needs addr[1:0] = 00.
- **Byte enables:**
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << {addr[1], 1'b0}.
  - Word: 1111.
  - mem_be = 0 when mem_req = 0.
- **mem_wdata:**
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- **Load data:**
  - Select the lane from mem_rdata using the latched addr[1:0].
  - Extend bit 7 (byte) or bit 15 (half), or fill with zeros when lunsigned.
  - Stores leave rdata unchanged.
- **Protocol tolerance:**
  - mem_rvalid in IDLE or DONE is ignored.
  - mem_rvalid in REQ without mem_gnt is ignored.
- **Reset:** takes effect at the next edge from any state.
  - State returns to IDLE.
  - mem_req, done, misalign and rdata go to 0.
  - An in-flight response arriving after reset is dropped.

## Timing
- **Reset values:** stall 0, rdata 0, done 0, misalign 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0.
- **Zero-wait memory** (gnt in REQ, rvalid one cycle later):
  - Cycle 0: IDLE accept, stall = 1.
  - Cycle 1: REQ.
  - Cycle 2: WAIT, rvalid.
  - Cycle 3: DONE, rdata valid, stall = 0.
  - Four cycles per access; stall is high for cycles 0–2.
- **Same-cycle gnt and rvalid:** three cycles per access.
- **Misaligned access:** two cycles (IDLE, then DONE with misalign = 1).
- **Back-to-back accesses:** the earliest a new access can be accepted is the cycle after DONE.

## Structure
- **Shared defines header:** size codes (W = 11, H = 10, B = 01) and the LSU state encoding (IDLE 00, REQ 01, WAIT 10, DONE 11).
- **lsu_align sub-module:** combinational. Generates byte enables and the store-data replicate, and does load lane-select and extend. The FSM and registers stay in xgriscv_lsu.

## Test plan
- **Load word, zero-wait.** lw at addr 0x100, mem_rdata = 0xDEADBEEF → mem_be = 1111, mem_addr = 0x100, done in cycle 3, rdata = 0xDEADBEEF.
- **Byte loads, signed and unsigned.** lb at 0x103 with mem_rdata = 0x80FF_0000 → mem_be = 1000, rdata = 0xFFFFFF80. lbu at the same address → rdata = 0x00000080.
- **Store half with grant delay.** sh at 0x202, wdata = 0x1234ABCD, gnt delayed 3 cycles → mem_req held with be = 1100, wdata = 0xABCDABCD, mem_we = 1; stall stays high until DONE.
- **Misaligned word and illegal size.** lw at 0x0000_0006 → misalign pulse, mem_req never asserted, stall high exactly 1 cycle. Size 00 → same response.
- **Same-cycle response.** gnt and rvalid together in REQ → DONE on the next cycle; total 3 cycles.
- **Reset mid-transaction.** Reset asserted in WAIT, then a stray rvalid → IDLE, all outputs 0, no done pulse, next lw completes normally.

Source files
------------

// File: rtl/xgriscv_lsu_pkg.sv
// Shared definitions for the xgriscv load/store unit: widths, size codes, FSM encoding.
package xgriscv_lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;
    localparam int unsigned SZ_W = 2;
    localparam int unsigned ST_W = 2;

    // Access size codes (shared by lwhb and swhb)
    localparam logic [SZ_W-1:0] SIZE_W   = 2'b11;
    localparam logic [SZ_W-1:0] SIZE_H   = 2'b10;
    localparam logic [SZ_W-1:0] SIZE_B   = 2'b01;
    localparam logic [SZ_W-1:0] SIZE_ILL = 2'b00;

    // LSU state encoding
    localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
    localparam logic [ST_W-1:0] ST_REQ  = 2'b01;
    localparam logic [ST_W-1:0] ST_WAIT = 2'b10;
    localparam logic [ST_W-1:0] ST_DONE = 2'b11;

    // Attributes of the accepted access, held until the response returns
    typedef struct packed {
        logic            we;
        logic [SZ_W-1:0] size;
        logic            lunsigned;
        logic [1:0]      addr_lo;
    } lsu_acc_t;

    // Size must be nonzero and the address naturally aligned for that size
    function automatic logic access_legal(input logic [SZ_W-1:0] size,
                                          input logic [1:0]      addr_lo);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = (addr_lo[0] == 1'b0);
            SIZE_W:  ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/xgriscv_lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store replicate, load select and extend.
module xgriscv_lsu_align
    import xgriscv_lsu_pkg::*;
(
    input  logic [SZ_W-1:0] size,
    input  logic [1:0]      addr_lo,
    input  logic            lunsigned,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] wdata_rep_c,
    output logic [XLEN-1:0] load_c
);

    logic [XLEN-1:0] lane;

    // Byte enables and store data replicated across all lanes of the access size
    always_comb begin
        be_c        = '0;
        wdata_rep_c = wdata;
        case (size)
            SIZE_B: begin
                be_c        = BE_W'(4'b0001 << addr_lo);
                wdata_rep_c = {4{wdata[7:0]}};
            end
            SIZE_H: begin
                be_c        = BE_W'(4'b0011 << {addr_lo[1], 1'b0});
                wdata_rep_c = {2{wdata[15:0]}};
            end
            SIZE_W: begin
                be_c        = 4'b1111;
                wdata_rep_c = wdata;
            end
            default: begin
                be_c        = '0;
                wdata_rep_c = wdata;
            end
        endcase
    end

    assign lane = mem_rdata >> {addr_lo, 3'b000};

    // Move the addressed lane to bit 0, then sign- or zero-extend
    always_comb begin
        load_c = mem_rdata;
        case (size)
            SIZE_B:  load_c = lunsigned ? {24'h000000, lane[7:0]}
                                        : {{24{lane[7]}}, lane[7:0]};
            SIZE_H:  load_c = lunsigned ? {16'h0000, lane[15:0]}
                                        : {{16{lane[15]}}, lane[15:0]};
            default: load_c = mem_rdata;
        endcase
    end

endmodule

// File: rtl/xgriscv_lsu.sv
// MEM-stage load/store unit: one req/gnt/rvalid bus transaction per load or store.
module xgriscv_lsu
    import xgriscv_lsu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            memwrite,
    input  logic [1:0]      lwhb,
    input  logic [1:0]      swhb,
    input  logic            lunsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic [XLEN-1:0] rdata,
    output logic            done,
    output logic            misalign,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    logic [ST_W-1:0] state_q, state_d;
    lsu_acc_t        acc_q, acc_d;
    logic [BE_W-1:0] be_lat_q, be_lat_d;
    logic [XLEN-1:0] rdata_d, mem_addr_d, mem_wdata_d;
    logic [BE_W-1:0] mem_be_d;
    logic            done_d, misalign_d, mem_req_d, mem_we_d;

    logic [SZ_W-1:0] cur_size, sel_size;
    logic [1:0]      sel_addr_lo;
    logic            cur_legal;
    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] wdata_rep_c, load_c;

    assign cur_size  = memwrite ? swhb : lwhb;
    assign cur_legal = access_legal(cur_size, addr[1:0]);

    // In IDLE the lane logic sees the incoming access; afterwards the latched one
    assign sel_size    = (state_q == ST_IDLE) ? cur_size  : acc_q.size;
    assign sel_addr_lo = (state_q == ST_IDLE) ? addr[1:0] : acc_q.addr_lo;

    xgriscv_lsu_align u_align (
        .size        (sel_size),
        .addr_lo     (sel_addr_lo),
        .lunsigned   (acc_q.lunsigned),
        .wdata       (wdata),
        .mem_rdata   (mem_rdata),
        .be_c        (be_c),
        .wdata_rep_c (wdata_rep_c),
        .load_c      (load_c)
    );

    // Pipeline hold while an access is pending; released in DONE
    assign stall = !reset && (((state_q == ST_IDLE) && valid_i) ||
                              (state_q == ST_REQ) || (state_q == ST_WAIT));

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        be_lat_d    = be_lat_q;
        rdata_d     = rdata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = mem_we;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (cur_legal) begin
                        acc_d.we        = memwrite;
                        acc_d.size      = cur_size;
                        acc_d.lunsigned = lunsigned;
                        acc_d.addr_lo   = addr[1:0];
                        be_lat_d        = be_c;
                        mem_addr_d      = {addr[XLEN-1:2], 2'b00};
                        mem_wdata_d     = wdata_rep_c;
                        mem_we_d        = memwrite;
                        state_d         = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (mem_rvalid) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                        if (!acc_q.we) rdata_d = load_c;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                    if (!acc_q.we) rdata_d = load_c;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        mem_req_d = (state_d == ST_REQ);
        mem_be_d  = mem_req_d ? be_lat_d : '0;
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            be_lat_q  <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            be_lat_q  <= be_lat_d;
            rdata     <= rdata_d;
            done      <= done_d;
            misalign  <= misalign_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Directed self-checking bench for xgriscv_lsu.
module tb_xgriscv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        memwrite;
    logic [1:0]  lwhb;
    logic [1:0]  swhb;
    logic        lunsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    xgriscv_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .memwrite   (memwrite),
        .lwhb       (lwhb),
        .swhb       (swhb),
        .lunsigned  (lunsigned),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .rdata      (rdata),
        .done       (done),
        .misalign   (misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Present an access at the current negedge (inputs settle before next posedge)
    task automatic start_op(input logic we, input logic [1:0] sz, input logic lu,
                            input logic [31:0] a, input logic [31:0] wd);
        valid_i   = 1'b1;
        memwrite  = we;
        lwhb      = we ? 2'b00 : sz;
        swhb      = we ? sz : 2'b00;
        lunsigned = lu;
        addr      = a;
        wdata     = wd;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_i = 1'b1; memwrite = 1'b0; lwhb = 2'b11; swhb = 2'b00;
        lunsigned = 1'b0; addr = 32'h100; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({stall, done, misalign, mem_req, mem_we} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {stall, done, misalign, mem_req, mem_we});
        end
        total++;
        if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'b0) begin
            bad++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h be=%b want all 0", rdata, mem_addr, mem_wdata, mem_be);
        end
        valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        start_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall_c0 got=%b want=1", stall); end
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h100}) begin
            bad++; $display("FAIL lw_req req=%b we=%b be=%b addr=%h want 1 0 1111 00000100", mem_req, mem_we, mem_be, mem_addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req, mem_be, stall, done} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
            bad++; $display("FAIL lw_wait req=%b be=%b stall=%b done=%b want 0 0000 1 0", mem_req, mem_be, stall, done);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({done, stall, rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            bad++; $display("FAIL lw_done done=%b stall=%b rdata=%h want 1 0 deadbeef", done, stall, rdata);
        end
        mem_rvalid = 1'b0; valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({done, stall} !== 2'b00) begin bad++; $display("FAIL lw_after done=%b stall=%b want 00", done, stall); end
    endtask

    task automatic test_load_byte();
        logic [31:0] exp_rd [2];
        exp_rd[0] = 32'hFFFFFF80;
        exp_rd[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            start_op(1'b0, 2'b01, (i == 1), 32'h103, 32'h0);
            @(negedge clk);
            total++;
            if ({mem_req, mem_be, mem_addr} !== {1'b1, 4'b1000, 32'h100}) begin
                bad++; $display("FAIL lb_req[%0d] req=%b be=%b addr=%h want 1 1000 00000100", i, mem_req, mem_be, mem_addr);
            end
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF0000;
            @(negedge clk);
            total++;
            if ({done, rdata} !== {1'b1, exp_rd[i]}) begin
                bad++; $display("FAIL lb_data[%0d] done=%b rdata=%h want 1 %h", i, done, rdata, exp_rd[i]);
            end
            mem_rvalid = 1'b0; valid_i = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_store_half();
        start_op(1'b1, 2'b10, 1'b0, 32'h202, 32'h1234ABCD);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall} !==
                {1'b1, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD, 1'b1}) begin
                bad++; $display("FAIL sh_hold[%0d] req=%b we=%b be=%b addr=%h wd=%h stall=%b", c, mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall);
            end
            mem_rvalid = (c == 1);
            mem_rdata  = 32'h5A5A5A5A;
        end
        mem_rvalid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        total++;
        if ({mem_req, stall, done} !== 3'b010) begin
            bad++; $display("FAIL sh_wait req=%b stall=%b done=%b want 0 1 0", mem_req, stall, done);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        total++;
        if ({done, stall, rdata} !== {1'b1, 1'b0, 32'h00000080}) begin
            bad++; $display("FAIL sh_done done=%b stall=%b rdata=%h want 1 0 00000080", done, stall, rdata);
        end
        mem_rvalid = 1'b0; valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_misalign();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) start_op(1'b0, 2'b11, 1'b0, 32'h6, 32'h0);
            else        start_op(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
            total++;
            if ({stall, mem_req} !== 2'b10) begin
                bad++; $display("FAIL mis_c0[%0d] stall=%b req=%b want 1 0", i, stall, mem_req);
            end
            @(negedge clk);
            total++;
            if ({misalign, done, mem_req, stall} !== 4'b1000) begin
                bad++; $display("FAIL mis_c1[%0d] mis=%b done=%b req=%b stall=%b want 1000", i, misalign, done, mem_req, stall);
            end
            valid_i = 1'b0;
            @(negedge clk);
            total++;
            if ({misalign, mem_req} !== 2'b00) begin
                bad++; $display("FAIL mis_c2[%0d] mis=%b req=%b want 00", i, misalign, mem_req);
            end
        end
    endtask

    task automatic test_same_cycle();
        start_op(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80010000;
        @(negedge clk);
        total++;
        if ({done, stall, mem_req, rdata} !== {1'b1, 1'b0, 1'b0, 32'hFFFF8001}) begin
            bad++; $display("FAIL same_cycle done=%b stall=%b req=%b rdata=%h want 1 0 0 ffff8001", done, stall, mem_req, rdata);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_op(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; reset = 1'b1; valid_i = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall); end
        @(negedge clk);
        reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        #1;
        total++;
        if ({done, mem_req, mem_addr, mem_be, rdata} !== 70'b0) begin
            bad++; $display("FAIL rst_outs done=%b req=%b addr=%h be=%b rdata=%h want all 0", done, mem_req, mem_addr, mem_be, rdata);
        end
        @(negedge clk);
        total++;
        if ({done, stall, rdata} !== 34'b0) begin
            bad++; $display("FAIL rst_stray done=%b stall=%b rdata=%h want 0 0 0", done, stall, rdata);
        end
        mem_rvalid = 1'b0;
        start_op(1'b0, 2'b11, 1'b0, 32'h300, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        total++;
        if ({done, rdata} !== {1'b1, 32'hCAFEF00D}) begin
            bad++; $display("FAIL rst_next done=%b rdata=%h want 1 cafef00d", done, rdata);
        end
        mem_rvalid = 1'b0; valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        start_op(1'b0, 2'b01, 1'b1, 32'h101, 32'h0);
        @(negedge clk);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000AB00;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        total++;
        if ({done, rdata, stall} !== {1'b1, 32'h000000AB, 1'b0}) begin
            bad++; $display("FAIL b2b_first done=%b rdata=%h stall=%b want 1 000000ab 0", done, rdata, stall);
        end
        start_op(1'b1, 2'b11, 1'b0, 32'h104, 32'h01020304);
        @(negedge clk);
        total++;
        if ({stall, mem_req, done} !== 3'b100) begin
            bad++; $display("FAIL b2b_accept stall=%b req=%b done=%b want 100", stall, mem_req, done);
        end
        @(negedge clk);
        total++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1111, 32'h104, 32'h01020304}) begin
            bad++; $display("FAIL b2b_req req=%b we=%b be=%b addr=%h wd=%h", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; valid_i = 1'b0;
        total++;
        if ({done, rdata} !== {1'b1, 32'h000000AB}) begin
            bad++; $display("FAIL b2b_store done=%b rdata=%h want 1 000000ab", done, rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
